cmp_seq_ctrl: RTL and testbench
===============================

Name: cmp_seq_ctrl

Overview:
Multi-cycle wide-operand comparator controller for the pipeline's branch/compare path. It accepts two WIDTH-bit operands on a start pulse and compares them one 8-bit slice per cycle, most significant slice first. Each slice goes through a single shared comparator_8, with the running EQ/GT fed back as the cascade inputs. It stops early on the first unequal slice, then reports eq/gt/lt with a one-cycle done pulse.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 8
SLICES, WIDTH/8, number of 8-bit slices; derived, not overridden

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only while idle (busy=0)
signed_cmp  input  1  1 = two's-complement compare, 0 = unsigned; latched with operands
a_in  input  WIDTH  operand A; latched on accepted start
b_in  input  WIDTH  operand B; latched on accepted start
busy  output  1  high while a compare is in progress
done  output  1  one-cycle pulse when results are valid
eq  output  1  A == B
gt  output  1  A > B
lt  output  1  A < B

Behaviour:
- Reset: state=IDLE; busy=0, done=0, eq=0, gt=0, lt=0; slice index=SLICES-1; eq_acc=1, gt_acc=0.
- States: IDLE, COMPARE.
- IDLE to COMPARE: on an edge with start=1.
  - Latch a_in, b_in and signed_cmp.
  - Set index=SLICES-1, eq_acc=1, gt_acc=0, busy=1.
- start while busy=1: ignored; latched operands are not disturbed.
- COMPARE, each edge:
  - comparator_8 receives the slice [8*index+7 : 8*index] of A and B, plus EQprev=eq_acc and GTprev=gt_acc.
  - Cascade rules: EQ = EQprev & (sliceA == sliceB); GT = GTprev | (EQprev & sliceA > sliceB), unsigned.
  - Signed mode: bit 7 of the top slice (index=SLICES-1) is inverted on both operands before the comparator. All other slices are unchanged.
  - Register EQ into eq_acc and GT into gt_acc.
- Termination: if index==0 or the new EQ==0, at that same edge:
  - eq <= EQ, gt <= GT, lt <= ~EQ & ~GT.
  - done <= 1, busy <= 0, state <= IDLE.
  - Otherwise index decrements and the state stays in COMPARE.
- Latency, counted from the start-accept edge: 1 to SLICES cycles.
  - Cycle count = 1 + number of leading equal slices, capped at SLICES.
  - Fully equal operands take SLICES cycles.
- Outputs after done:
  - done is high for exactly one cycle.
  - eq/gt/lt hold their values until the next completion or reset.
  - eq/gt/lt are not cleared on start.
  - Exactly one of eq/gt/lt is high after the first completion.
- Back-to-back: the done cycle is an IDLE cycle, so start=1 in that cycle is accepted. No bubble is required.
- Reset mid-COMPARE: abort immediately to reset values. No done pulse is produced.
- WIDTH=8: a single slice, so every compare completes in 1 cycle.

Decomposition:
- Shared include/package: SLICE_W=8 and the state encodings IDLE=1'b0, COMPARE=1'b1.
- Sub-module: a single instance of the existing comparator_8 as the slice datapath.
- Controller scope: the slice mux, the signed MSB inversion and the FSM/accumulators live in cmp_seq_ctrl.
- No other sub-modules.

Test Plan:
1. Equal operands, WIDTH=32, unsigned: A=B=0x12345678 → busy for 4 cycles; done at 4th edge after accept; eq=1, gt=0, lt=0.
2. Early exit on top slice, unsigned: A=0x80000000, B=0x00000001 → done after 1 cycle; gt=1, eq=0, lt=0.
3. Same operands, signed_cmp=1: A=0x80000000, B=0x00000001 → done after 1 cycle; lt=1, eq=0, gt=0.
4. Mismatch in lowest slice: A=0xDEADBE00, B=0xDEADBEFF → done after 4 cycles; lt=1. Repeat with start re-asserted in the done cycle and A=5, B=5 → accepted with no gap; eq=1 after 4 more cycles.
5. start pulsed mid-compare with different operands: first compare completes with its original result, and the second start is ignored (no second done).
6. Reset asserted at cycle 2 of a 4-slice compare → next cycle busy=0, done=0, eq=gt=lt=0; no done pulse follows. A later start with A=3, B=7 → lt=1 after 4 cycles.

Source files
------------

// File: rtl/cmp_seq_ctrl_pkg.sv
// rtl/cmp_seq_ctrl_pkg.sv - shared slice width, FSM encoding and index sizing helper
package cmp_seq_ctrl_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_e;

    // Keeps the slice index at least one bit wide for the single-slice case.
    function automatic int idx_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/cmp_seq_ctrl_comparator_8.sv
// rtl/cmp_seq_ctrl_comparator_8.sv - cascadable unsigned 8-bit magnitude comparator slice
module comparator_8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       eq_prev_i,
    input  logic       gt_prev_i,
    output logic       eq_o,
    output logic       gt_o
);

    assign eq_o = eq_prev_i & (a_i == b_i);
    assign gt_o = gt_prev_i | (eq_prev_i & (a_i > b_i));

endmodule

// File: rtl/cmp_seq_ctrl.sv
// rtl/cmp_seq_ctrl.sv - multi-cycle wide comparator, one 8-bit slice per cycle, MS slice first
module cmp_seq_ctrl
    import cmp_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_cmp,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int SLICES = WIDTH / SLICE_W;
    localparam int IDX_W  = idx_width(SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               signed_q;
    logic [IDX_W-1:0]   idx_q;
    logic               eq_acc_q, gt_acc_q;
    logic               busy_q, done_q, eq_q, gt_q, lt_q;

    logic [SLICE_W-1:0] slice_a_d, slice_b_d;
    logic               cmp_eq_d, cmp_gt_d;

    // Flipping the sign bit of the top slice maps two's-complement order onto unsigned order.
    always_comb begin
        slice_a_d = a_q[{idx_q, 3'b000} +: SLICE_W];
        slice_b_d = b_q[{idx_q, 3'b000} +: SLICE_W];
        if (signed_q && (idx_q == LAST_IDX)) begin
            slice_a_d[SLICE_W-1] = ~slice_a_d[SLICE_W-1];
            slice_b_d[SLICE_W-1] = ~slice_b_d[SLICE_W-1];
        end
    end

    comparator_8 u_cmp (
        .a_i       (slice_a_d),
        .b_i       (slice_b_d),
        .eq_prev_i (eq_acc_q),
        .gt_prev_i (gt_acc_q),
        .eq_o      (cmp_eq_d),
        .gt_o      (cmp_gt_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= LAST_IDX;
            eq_acc_q <= 1'b1;
            gt_acc_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a_in;
                        b_q      <= b_in;
                        signed_q <= signed_cmp;
                        idx_q    <= LAST_IDX;
                        eq_acc_q <= 1'b1;
                        gt_acc_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= COMPARE;
                    end
                end
                COMPARE: begin
                    eq_acc_q <= cmp_eq_d;
                    gt_acc_q <= cmp_gt_d;
                    if ((idx_q == '0) || !cmp_eq_d) begin
                        eq_q    <= cmp_eq_d;
                        gt_q    <= cmp_gt_d;
                        lt_q    <= ~cmp_eq_d & ~cmp_gt_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb/tb_cmp_seq_ctrl.sv - directed vector bench for cmp_seq_ctrl at WIDTH=32
module tb_cmp_seq_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             signed_cmp;
    logic [WIDTH-1:0] a_in, b_in;
    logic             busy, done, eq, gt, lt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cmp_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_cmp (signed_cmp),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .eq         (eq),
        .gt         (gt),
        .lt         (lt)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic        x_eq;
        logic        x_gt;
        logic        x_lt;
        int          x_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts rising edges after the current point until done is seen (bounded).
    task automatic wait_done(output int cyc, output logic got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) got = 1'b1;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int cyc, input logic got);
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_cycles"}, 32'(cyc), 32'(v.x_cyc));
        chk({tag, "_eq"}, 32'(eq), 32'(v.x_eq));
        chk({tag, "_gt"}, 32'(gt), 32'(v.x_gt));
        chk({tag, "_lt"}, 32'(lt), 32'(v.x_lt));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        signed_cmp = v.sgn;
        a_in       = v.a;
        b_in       = v.b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic expect_no_done(input string tag, input int ncyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk({tag, "_no_done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        int   cyc;
        logic got;
        vec_t v;

        vecs[0] = '{1'b0, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0, 4};
        vecs[1] = '{1'b0, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 1};
        vecs[2] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b1, 1};
        vecs[3] = '{1'b0, 32'hDEADBE00, 32'hDEADBEFF, 1'b0, 1'b0, 1'b1, 4};
        vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
        vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};
        vecs[6] = '{1'b0, 32'h00120000, 32'h00110000, 1'b0, 1'b1, 1'b0, 2};
        vecs[7] = '{1'b1, 32'h12345678, 32'h1234FF78, 1'b0, 1'b0, 1'b1, 3};
        vecs[8] = '{1'b1, 32'hFFFFFF00, 32'hFFFFFF01, 1'b0, 1'b0, 1'b1, 4};
        vecs[9] = '{1'b1, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 4};

        reset = 1'b1; start = 1'b0; signed_cmp = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_eq", 32'(eq), 32'd0);
        chk("rst_gt", 32'(gt), 32'd0);
        chk("rst_lt", 32'(lt), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i]);
            chk($sformatf("v%0d_busy_after_accept", i), 32'(busy), 32'd1);
            wait_done(cyc, got);
            check_result($sformatf("v%0d", i), vecs[i], cyc, got);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
        end

        // Back-to-back: restart in the done cycle with no bubble.
        issue(vecs[3]);
        wait_done(cyc, got);
        check_result("b2b_first", vecs[3], cyc, got);
        signed_cmp = 1'b0; a_in = 32'd5; b_in = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_accepted_busy", 32'(busy), 32'd1);
        chk("b2b_done_dropped", 32'(done), 32'd0);
        wait_done(cyc, got);
        v = '{1'b0, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 4};
        check_result("b2b_second", v, cyc, got);

        // A start while busy must not disturb the latched operands.
        v = '{1'b0, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1, 4};
        issue(v);
        @(posedge clk);
        #1;
        signed_cmp = 1'b1; a_in = 32'hFFFFFFFF; b_in = 32'h0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, got);
        check_result("ignore", v, cyc + 2, got);
        expect_no_done("ignore", 10);

        // Reset in cycle 2 of a 4-slice compare aborts without a done pulse.
        v = '{1'b0, 32'd3, 32'd7, 1'b0, 1'b0, 1'b1, 4};
        issue(v);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_eq", 32'(eq), 32'd0);
        chk("abort_gt", 32'(gt), 32'd0);
        chk("abort_lt", 32'(lt), 32'd0);
        expect_no_done("abort", 8);
        issue(v);
        wait_done(cyc, got);
        check_result("after_abort", v, cyc, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
